memory_bus_arbiter: RTL

- Parametrised N-channel arbiter between cache-side requesters (instruction cache, data cache, future DMA/debug ports) and the single memory port.
- Generalises the fixed two-cache mux: selectable fixed or round-robin priority, and multiple outstanding requests.
- Responses are steered to the requester through an in-order tag FIFO.
- Sits between the cache instances and the RAM controller.

---
 rtl/memory_bus_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_bus_arbiter
// Function : N-channel arbiter from cache-side requesters onto one memory
//            port. Fixed or round-robin grant, several requests in flight,
//            responses returned in order through a tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter #(
  parameter int CHANNELS        = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int PRIORITY_MODE   = 0,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            ch_read,
  input  logic [CHANNELS-1:0]            ch_write,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_address,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ch_wdata,
  output logic [CHANNELS-1:0]            ch_accept,
  output logic [CHANNELS-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]          ch_rdata,
  output logic [ADDR_WIDTH-1:0]          memory_address,
  output logic                           memory_read,
  output logic                           memory_write,
  output logic [DATA_WIDTH-1:0]          memory_out,
  input  logic                           memory_accept,
  input  logic [DATA_WIDTH-1:0]          memory_in,
  input  logic                           memory_read_ready,
  input  logic                           memory_write_ready,
  output logic                           fifo_full,
  output logic                           protocol_error
);

  localparam int c_ID_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_DEPTH = 1 << c_PTR_W;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(MAX_OUTSTANDING);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [c_ID_W-1:0]  c_CH_LAST  = c_ID_W'(CHANNELS - 1);

  // Grant and response decode
  logic [CHANNELS-1:0] w_req;
  logic                w_grant_valid;
  logic [c_ID_W-1:0]   w_grant_id;
  logic [c_ID_W-1:0]   w_idx;
  int                  w_sum;
  logic                w_grant_is_write;
  logic                w_issue;
  logic                w_pop;
  logic                w_resp_err;
  logic                w_fifo_empty;
  logic [c_ID_W-1:0]   w_head_id;
  logic                w_head_is_write;

  // State
  logic [c_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;

  // Tag storage: channel id and transaction type of each outstanding request
  logic [c_ID_W-1:0] tag_id_q [c_DEPTH];
  logic              tag_wr_q [c_DEPTH];

  assign w_req        = ch_read | ch_write;
  assign w_fifo_empty = (count_q == '0);
  assign fifo_full    = (count_q == c_FULL);
  assign protocol_error = err_q;

  assign w_head_id       = tag_id_q[rd_ptr_q];
  assign w_head_is_write = tag_wr_q[rd_ptr_q];

  // Pick the winning channel: scan starts at 0 (fixed) or at rr_ptr (round-robin)
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_idx         = '0;
    w_sum         = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_sum = (PRIORITY_MODE == 1) ? (int'(rr_ptr_q) + k) : k;
      if (w_sum >= CHANNELS) begin
        w_sum = w_sum - CHANNELS;
      end
      w_idx = c_ID_W'(w_sum);
      if (!w_grant_valid && w_req[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_idx;
      end
    end
  end

  // A simultaneous read+write request on one channel is issued as a write
  assign w_grant_is_write = ch_write[w_grant_id];

  // Full blocks issue even when a pop lands in the same cycle
  assign w_issue = reset && w_grant_valid && memory_accept && !fifo_full;

  assign memory_address = ch_address[int'(w_grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign memory_out     = ch_wdata[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign memory_read    = w_issue && !w_grant_is_write;
  assign memory_write   = w_issue && w_grant_is_write;
  assign ch_rdata       = memory_in;

  // Classify the memory response against the FIFO head
  always_comb begin
    w_pop      = 1'b0;
    w_resp_err = 1'b0;
    if (memory_read_ready && memory_write_ready) begin
      w_resp_err = 1'b1;
    end else if (memory_read_ready || memory_write_ready) begin
      if (w_fifo_empty) begin
        w_resp_err = 1'b1;
      end else if (w_head_is_write != memory_write_ready) begin
        w_resp_err = 1'b1;
      end else begin
        w_pop = reset;
      end
    end
  end

  // One-hot accept/ready pulses toward the requesters
  always_comb begin
    ch_accept = '0;
    ch_ready  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_accept[i] = w_issue && (w_grant_id == c_ID_W'(i));
      ch_ready[i]  = w_pop && (w_head_id == c_ID_W'(i));
    end
  end

  // Next-state for FIFO pointers, occupancy, round-robin pointer and error flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q | w_resp_err;
    if (w_issue) begin
      wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + c_PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + c_PTR_W'(1);
    end
    if (w_issue && !w_pop) begin
      count_d = count_q + c_CNT_W'(1);
    end else if (!w_issue && w_pop) begin
      count_d = count_q - c_CNT_W'(1);
    end
    if ((PRIORITY_MODE == 1) && w_issue) begin
      rr_ptr_d = (w_grant_id == c_CH_LAST) ? '0 : w_grant_id + c_ID_W'(1);
    end
  end

  // Control state register; reset drops everything in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Tag payload write; contents are only meaningful below count_q
  always_ff @(posedge clock) begin
    if (w_issue) begin
      tag_id_q[wr_ptr_q] <= w_grant_id;
      tag_wr_q[wr_ptr_q] <= w_grant_is_write;
    end
  end

endmodule
`default_nettype wire
